// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the iterative multiplier: operand width, FSM
// encodings and the operand-magnitude helper.
package seq_mult_unit_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_NEG_LO = 3'd2,
        S_NEG_HI = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [ALU_WIDTH-1:0] twos_neg(input logic [ALU_WIDTH-1:0] x);
        return ~x + {{(ALU_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/seq_mult_unit_hybrid_add.sv
// HybridAdd: ripple lower half, carry-select upper half, with carry-in and
// carry-out. Shared by every phase of the multiplier.
module seq_mult_unit_hybrid_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int HALF = WIDTH / 2;
    localparam int UPPER = WIDTH - HALF;

    logic [HALF:0]  lo;
    logic [UPPER:0] hi0;
    logic [UPPER:0] hi1;

    assign lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};
    assign hi0 = {1'b0, a[WIDTH-1:HALF]} + {1'b0, b[WIDTH-1:HALF]};
    assign hi1 = hi0 + {{UPPER{1'b0}}, 1'b1};

    // Upper half is precomputed for both carries; the lower carry picks one.
    assign {cout, sum} = lo[HALF] ? {hi1, lo[HALF-1:0]} : {hi0, lo[HALF-1:0]};

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative 32x32->64 shift-add multiplier (signed/unsigned) around one
// shared HybridAdd; 34-clock fixed latency with start/busy/done handshake.
module seq_mult_unit
    import seq_mult_unit_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [2:0]       dbg_state
);

    // Handshake: start (with signed_op/a/b) is accepted on any rising edge
    // where the FSM is in IDLE or DONE; it is ignored while busy. done pulses
    // for one cycle when prod_hi/prod_lo carry the new result, which then
    // holds until the next result or reset.

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             cl;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign mag_a     = (signed_op && a[WIDTH-1]) ? twos_neg(a) : a;
    assign mag_b     = (signed_op && b[WIDTH-1]) ? twos_neg(b) : b;
    assign dbg_state = state;

    // Adder input mux: accumulate in RUN, two-word negate in NEG_LO/NEG_HI.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_RUN: begin
                add_a = acc;
                add_b = q_reg[0] ? m_reg : '0;
            end
            S_NEG_LO: begin
                add_a   = ~q_reg;
                add_cin = 1'b1;
            end
            S_NEG_HI: begin
                add_a   = ~acc;
                add_cin = cl;
            end
            default: ;
        endcase
    end

    seq_mult_unit_hybrid_add #(.WIDTH(WIDTH)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            m_reg   <= '0;
            q_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            cl      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= mag_a;
                        q_reg <= mag_b;
                        acc   <= '0;
                        cnt   <= '0;
                        cl    <= 1'b0;
                        neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // 65-bit {carry, sum, Q} shifted right by one.
                    acc   <= {add_cout, add_sum[WIDTH-1:1]};
                    q_reg <= {add_sum[0], q_reg[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_NEG_LO;
                    end
                end
                S_NEG_LO: begin
                    if (neg) begin
                        q_reg <= add_sum;
                        cl    <= add_cout;
                    end
                    state <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    if (neg) begin
                        acc <= add_sum;
                    end
                    prod_hi <= neg ? add_sum : acc;
                    prod_lo <= q_reg;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
